match_eliminate: RTL
====================

Name: match_eliminate

Overview:
- Finds runs of MIN_RUN or more identical, non-empty pieces in any row or column of the board.
- Clears those cells to EMPTY and reports how many cells it cleared.
- Sits upstream of the gravity/refill stage: its new_board output is that stage's board input.
- Multi-cycle scan with a start/done handshake.

Parameters:
- ROWS, 8, board rows.
- COLS, 8, board columns.
- CW, 3, bits per cell; code 0 = EMPTY, codes 1..7 = piece types.
- MIN_RUN, 3, minimum run length that counts as a match (range 2..ROWS).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request; samples board.
- board  in  ROWS*COLS*CW  input board; cell (r,c) at bits [(r*COLS+c)*CW +: CW]; r=0 is the top row, c=0 is the left column.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse; results are valid on that cycle and are held afterwards.
- new_board  out  ROWS*COLS*CW  latched board with matched cells set to 0.
- cleared_cnt  out  7  number of distinct cells cleared (0..64).
- found  out  1  cleared_cnt != 0.

Behaviour:
- Reset: FSM to IDLE. busy=0, done=0, new_board=0, cleared_cnt=0, found=0. Internal mask and latched board cleared.
- Reset asserted mid-scan aborts the scan: no done pulse, outputs as at reset.
- IDLE: when start=1, latch board into bq, clear the 64-bit mask, set idx=0, go to SCAN_R.
- While busy, start is ignored and bq is not reloaded.
- SCAN_R, one row per cycle, idx 0..ROWS-1:
  - mask |= row match mask of row idx.
  - After idx=ROWS-1, reset idx to 0 and go to SCAN_C.
- SCAN_C, one column per cycle, same rule applied to column idx.
  - After idx=COLS-1, go to APPLY.
- APPLY:
  - new_board = bq with every masked cell set to 0.
  - cleared_cnt = popcount(mask).
  - found = |mask.
  - Go to DONE.
- DONE: done=1 for one cycle, busy drops to 0 on the same edge, return to IDLE.
- start is accepted again on the cycle after DONE.
- Latency: start at cycle 0 gives done at cycle ROWS+COLS+2 (18 with defaults).
- Line match rule:
  - A cell is marked if it is non-empty and lies in a maximal run of equal codes of length >= MIN_RUN.
  - Runs longer than MIN_RUN mark every cell in the run.
  - EMPTY cells never match, even in a run of EMPTY.
  - Runs do not wrap across line ends.
- A cell matched in both its row and its column (L/T/cross shapes) is counted once, because the mask is an OR.
- Board with no match: new_board == bq, cleared_cnt=0, found=0; done still pulses.
- Outputs are only updated in APPLY and hold their values until the next APPLY or reset.

Optional Feature:
- Macro: MATCH_SCORE_EN.
- Defined:
  - Adds output score [15:0], reset 0.
  - In APPLY, score += cleared_cnt * cleared_cnt, saturating at 16'hFFFF.
  - Adds input score_clr (1 bit); a synchronous clear that has priority over the APPLY add in the same cycle.
- Undefined: no score logic and no score or score_clr ports.
- All other behaviour is identical with or without the macro.

Decomposition:
- Package elim_pkg holds:
  - ROWS, COLS, CW, EMPTY=3'd0;
  - a state enum {IDLE, SCAN_R, SCAN_C, APPLY, DONE};
  - a function for the cell bit offset.
- Sub-module line_matcher (combinational) takes COLS cells of CW bits and MIN_RUN. It outputs a COLS-bit match mask.
- The top FSM instantiates line_matcher once and muxes the row or column into it each cycle.

Test Plan:
- Row 0 = 1,1,1,2,3,4,5,6, all other cells 0 -> row 0 cols 0..2 cleared, cleared_cnt=3, found=1, done exactly 18 cycles after start.
- Column 5 rows 2..6 all = 4, rest of board a no-match checkerboard of 2/3 -> 5 cells cleared, cleared_cnt=5.
- T-shape: row 3 cols 1..3 = 7 and col 2 rows 3..5 = 7 -> cells (3,1) (3,2) (3,3) (4,2) (5,2) cleared, cleared_cnt=5 (shared cell counted once).
- All-zero board -> new_board=0, cleared_cnt=0, found=0, done pulses. Row 0 = 0,0,2,2,0,3,3,3 -> only cols 5..7 cleared.
- start re-pulsed at cycle 5 with a different board -> ignored, result reflects the first board. Assert rst at cycle 9 -> no done pulse, all outputs 0, a new start then completes normally.
- With MATCH_SCORE_EN: two scans clearing 3 then 5 cells -> score 9 then 34. score_clr asserted on an APPLY cycle -> score=0.

Source files
------------

// File: rtl/elim_pkg.sv
// Shared geometry, state encoding and cell addressing for the match/eliminate stage.
// Pure declarations: no latency, no flow control.
package elim_pkg;
    localparam int ROWS     = 8;
    localparam int COLS     = 8;
    localparam int CW       = 3;
    localparam int CELLS    = ROWS * COLS;
    localparam int LINE_LEN = (ROWS > COLS) ? ROWS : COLS;
    localparam int IDX_W    = $clog2(LINE_LEN);
    localparam int CNT_W    = $clog2(CELLS + 1);

    localparam logic [CW-1:0] EMPTY = 3'd0;

    typedef enum logic [2:0] {IDLE, SCAN_R, SCAN_C, APPLY, DONE} state_t;

    function automatic int cell_off(input int r, input int c);
        return (r * COLS + c) * CW;
    endfunction
endpackage

// File: rtl/line_matcher.sv
// Marks every non-empty cell of one line that sits in a run of >= MIN_RUN equal codes.
// Latency: combinational. Backpressure: none.
// Every MIN_RUN-wide window of equal non-empty codes marks its cells; overlapping
// windows cover runs longer than MIN_RUN completely.
module line_matcher
    import elim_pkg::*;
#(
    parameter int LEN     = LINE_LEN,
    parameter int MIN_RUN = 3
) (
    input  logic [LEN*CW-1:0] cells,
    output logic [LEN-1:0]    match
);
    logic win;

    always_comb begin
        match = '0;
        win   = 1'b0;
        for (int s = 0; s <= LEN - MIN_RUN; s++) begin
            win = (cells[s*CW +: CW] != EMPTY);
            for (int k = 1; k < MIN_RUN; k++) begin
                if (cells[(s+k)*CW +: CW] != cells[s*CW +: CW]) win = 1'b0;
            end
            if (win) begin
                for (int k = 0; k < MIN_RUN; k++) match[s+k] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/match_eliminate.sv
// Clears row/column runs of >= MIN_RUN equal pieces; optional MATCH_SCORE_EN adds a score.
// Latency: start -> done in ROWS+COLS+2 cycles. Backpressure: start is ignored while busy.
// Results are held from the done pulse until the next completed scan or reset.
module match_eliminate
    import elim_pkg::*;
#(
    parameter int MIN_RUN = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [CELLS*CW-1:0]   board,
`ifdef MATCH_SCORE_EN
    input  logic                  score_clr,
    output logic [15:0]           score,
`endif
    output logic                  busy,
    output logic                  done,
    output logic [CELLS*CW-1:0]   new_board,
    output logic [CNT_W-1:0]      cleared_cnt,
    output logic                  found
);
    state_t                 state;
    logic [IDX_W-1:0]       idx;
    logic [CELLS*CW-1:0]    bq;
    logic [CELLS-1:0]       mask;
    logic [CELLS-1:0]       mask_nxt;
    logic [LINE_LEN*CW-1:0] line;
    logic [LINE_LEN-1:0]    line_hit;
    logic [CELLS*CW-1:0]    cleared_board;
    logic [CNT_W-1:0]       cnt_nxt;

    // Rows and columns share one matcher; unused tail positions stay EMPTY.
    always_comb begin
        line = '0;
        if (state == SCAN_R) begin
            for (int c = 0; c < COLS; c++) line[c*CW +: CW] = bq[cell_off(int'(idx), c) +: CW];
        end else begin
            for (int r = 0; r < ROWS; r++) line[r*CW +: CW] = bq[cell_off(r, int'(idx)) +: CW];
        end
    end

    line_matcher #(.LEN(LINE_LEN), .MIN_RUN(MIN_RUN)) u_line_matcher (
        .cells (line),
        .match (line_hit)
    );

    always_comb begin
        mask_nxt = mask;
        for (int k = 0; k < LINE_LEN; k++) begin
            if (state == SCAN_R && k < COLS && line_hit[k]) mask_nxt[int'(idx)*COLS + k] = 1'b1;
            if (state == SCAN_C && k < ROWS && line_hit[k]) mask_nxt[k*COLS + int'(idx)] = 1'b1;
        end
    end

    always_comb begin
        cleared_board = bq;
        for (int i = 0; i < CELLS; i++) begin
            if (mask[i]) cleared_board[i*CW +: CW] = EMPTY;
        end
        cnt_nxt = CNT_W'($countones(mask));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            idx         <= '0;
            bq          <= '0;
            mask        <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            new_board   <= '0;
            cleared_cnt <= '0;
            found       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        bq    <= board;
                        mask  <= '0;
                        idx   <= '0;
                        busy  <= 1'b1;
                        state <= SCAN_R;
                    end
                end
                SCAN_R: begin
                    mask <= mask_nxt;
                    if (idx == IDX_W'(ROWS - 1)) begin
                        idx   <= '0;
                        state <= SCAN_C;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                SCAN_C: begin
                    mask <= mask_nxt;
                    if (idx == IDX_W'(COLS - 1)) begin
                        idx   <= '0;
                        state <= APPLY;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                APPLY: begin
                    new_board   <= cleared_board;
                    cleared_cnt <= cnt_nxt;
                    found       <= |mask;
                    busy        <= 1'b0;
                    done        <= 1'b1;
                    state       <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MATCH_SCORE_EN
    logic [13:0] cnt_sq;
    logic [16:0] score_sum;

    always_comb begin
        cnt_sq    = {{(14-CNT_W){1'b0}}, cnt_nxt} * {{(14-CNT_W){1'b0}}, cnt_nxt};
        score_sum = {1'b0, score} + {3'b0, cnt_sq};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            score <= '0;
        end else if (score_clr) begin
            score <= '0;
        end else if (state == APPLY) begin
            score <= score_sum[16] ? 16'hFFFF : score_sum[15:0];
        end
    end
`endif
endmodule
